// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC ownership, registered ROM read, 2-entry skid buffer,
// redirect flush and halt drain. Define FETCH_PERF_EN to add transfer/redirect counters.
module fetch_sequencer #(
  parameter int             AW       = 8,
  parameter int             IW       = 16,
  parameter logic [IW-1:0]  NOP_INST = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt_req,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_out,
  output logic [AW-1:0] inst_pc,
  output logic          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   perf_fetched,
  output logic [15:0]   perf_redirects
`endif
);

  typedef enum logic [2:0] {PRIME, RUN, FLUSH, DRAIN, HALT} state_t;

  state_t        state, state_next;
  logic [AW-1:0] pc_p0;
  logic          vld_p1;
  logic [AW-1:0] pc_p1;
  logic [1:0]    count_p2;
  logic [IW-1:0] data_p2 [2];
  logic [AW-1:0] tag_p2  [2];

  logic          deliver, pop, push, issue;
  logic [1:0]    cnt_after_pop, occ_next;

  // Buffer bookkeeping: occupancy after this cycle's pop and push.
  always_comb begin
    deliver       = (state == RUN || state == DRAIN) && (count_p2 != 2'd0);
    pop           = deliver && inst_ready;
    cnt_after_pop = count_p2 - {1'b0, pop};
    push          = vld_p1 && (state == RUN || state == DRAIN) && !redirect;
    occ_next      = cnt_after_pop + {1'b0, push};
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    if (redirect) begin
      state_next = FLUSH;
    end else begin
      case (state)
        PRIME, FLUSH: begin
          issue      = 1'b1;
          state_next = RUN;
        end
        RUN: begin
          if (halt_req) state_next = DRAIN;
          else          issue      = !occ_next[1];
        end
        DRAIN: begin
          if (count_p2 == 2'd0 && !vld_p1) state_next = HALT;
        end
        HALT:    state_next = HALT;
        default: state_next = PRIME;
      endcase
    end
  end

  // Stage p0 -> p1: address issue; a redirect drops whatever is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PRIME;
      pc_p0    <= '0;
      vld_p1   <= 1'b0;
      count_p2 <= 2'd0;
    end else begin
      state  <= state_next;
      vld_p1 <= issue;
      if (redirect)   pc_p0 <= redirect_pc;
      else if (issue) pc_p0 <= pc_p0 + AW'(1);
      count_p2 <= redirect ? 2'd0 : occ_next;
    end
  end

  // Stage p1 -> p2: returned word joins the buffer behind any surviving entry.
  always_ff @(posedge clk) begin
    if (issue) pc_p1 <= pc_p0;
    if (pop) begin
      data_p2[0] <= data_p2[1];
      tag_p2[0]  <= tag_p2[1];
    end
    if (push) begin
      data_p2[cnt_after_pop[0]] <= rom_data;
      tag_p2[cnt_after_pop[0]]  <= pc_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && cnt_after_pop == 2'd2));
  end

  assign rom_addr   = pc_p0;
  assign inst_valid = deliver;
  assign inst_out   = deliver ? data_p2[0] : NOP_INST;
  assign inst_pc    = deliver ? tag_p2[0]  : '0;
  assign halted     = (state == HALT);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= 16'd0;
      perf_redirects <= 16'd0;
    end else begin
      if (pop && perf_fetched != 16'hFFFF)        perf_fetched   <= perf_fetched + 16'd1;
      if (redirect && perf_redirects != 16'hFFFF) perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic checked against a
// queue-based reference model of the fetch pipeline.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halt_req = 1'b0;
  logic        inst_valid;
  logic        ready = 1'b0;
  logic [15:0] inst_out;
  logic [7:0]  inst_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_redirects;
`endif

  fetch_sequencer #(.AW(8), .IW(16), .NOP_INST(16'h0000)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .inst_valid(inst_valid), .inst_ready(ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .halted(halted)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: buffered PCs and the PC whose ROM word arrives next cycle.
  localparam int M_PRIME = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3, M_HALT = 4;
  int         m_mode;
  logic [7:0] m_buf[$];
  logic [7:0] m_fly[$];
  logic [7:0] m_next;
  int         m_fetched, m_redirects;

  logic [33:0] exp_v;
  logic [33:0] act_v;
  assign act_v = {inst_valid, inst_out, inst_pc, rom_addr, halted};

  task automatic model_reset();
    m_mode = M_PRIME;
    m_buf.delete();
    m_fly.delete();
    m_next = 8'h00;
    m_fetched = 0;
    m_redirects = 0;
  endtask

  task automatic model_out();
    bit v;
    v = (m_mode == M_RUN || m_mode == M_DRAIN) && m_buf.size() > 0;
    if (v) exp_v = {1'b1, rom[m_buf[0]], m_buf[0], m_next, 1'b0};
    else   exp_v = {1'b0, 16'h0000, 8'h00, m_next, (m_mode == M_HALT)};
  endtask

  task automatic model_step();
    bit         v, arrive;
    int         sz;
    logic [7:0] apc;
    v = (m_mode == M_RUN || m_mode == M_DRAIN) && m_buf.size() > 0;
    sz = m_buf.size();
    if (v && ready) begin
      void'(m_buf.pop_front());
      if (m_fetched < 65535) m_fetched++;
    end
    if (redirect) begin
      if (m_redirects < 65535) m_redirects++;
      m_buf.delete();
      m_fly.delete();
      m_next = redirect_pc;
      m_mode = M_FLUSH;
      return;
    end
    arrive = m_fly.size() > 0;
    apc = arrive ? m_fly[0] : 8'h00;
    m_fly.delete();
    case (m_mode)
      M_PRIME, M_FLUSH: begin
        m_fly.push_back(m_next);
        m_next = m_next + 8'd1;
        m_mode = M_RUN;
      end
      M_RUN: begin
        if (arrive) m_buf.push_back(apc);
        if (halt_req) m_mode = M_DRAIN;
        else if (m_buf.size() < 2) begin
          m_fly.push_back(m_next);
          m_next = m_next + 8'd1;
        end
      end
      M_DRAIN: begin
        if (sz == 0 && !arrive) m_mode = M_HALT;
        else if (arrive) m_buf.push_back(apc);
      end
      default: ;
    endcase
  endtask

  task automatic look();
    @(negedge clk);
    model_out();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_cmp++;
    if (act_v !== 34'h0) begin
      n_fail++; $display("FAIL reset: dut=%h want=%h", act_v, 34'h0);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_stream();
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL stream cyc %0d: dut=%h want=%h", i, act_v, exp_v);
      end
      if (i == 2 || i == 3) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_out !== 16'h1000 + 16'(i - 2) || inst_pc !== 8'(i - 2)) begin
          n_fail++; $display("FAIL first_words cyc %0d: dut=%b/%h/%h want=1/%h/%h", i,
                             inst_valid, inst_out, inst_pc, 16'h1000 + 16'(i - 2), 8'(i - 2));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [15:0] held_out;
    logic [7:0]  held_addr;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look();
      if (i == 0) begin held_out = inst_out; held_addr = rom_addr; end
      n_cmp++;
      if (act_v !== exp_v || inst_out !== held_out || rom_addr !== held_addr) begin
        n_fail++; $display("FAIL stall cyc %0d: dut=%h want=%h held=%h/%h", i, act_v, exp_v, held_out, held_addr);
      end
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL resume cyc %0d: dut=%h want=%h", i, act_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin look(); tick(); end
    redirect = 1'b1; redirect_pc = 8'h40;
    look();
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++; $display("FAIL redirect_cycle: dut=%h want=%h", act_v, exp_v);
    end
    tick();
    redirect = 1'b0; ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL redirect cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      n_cmp++;
      if ((j <= 2 && inst_valid !== 1'b0) ||
          (j >= 3 && (inst_valid !== 1'b1 || inst_pc !== 8'h40 + 8'(j - 3)))) begin
        n_fail++; $display("FAIL redirect_target cyc %0d: dut=%b/%h", j, inst_valid, inst_pc);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
    redirect = 1'b1; redirect_pc = 8'hFE;
    look(); tick();
    redirect = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL wrap cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      if (j >= 3) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_pc !== want[j - 3]) begin
          n_fail++; $display("FAIL wrap_pc cyc %0d: dut=%b/%h want=1/%h", j, inst_valid, inst_pc, want[j - 3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    int xfers = 0;
    halt_req = 1'b1;
    for (int j = 0; j < 6; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL drain cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      if (inst_valid && ready) xfers++;
      tick();
    end
    halt_req = 1'b0;
    for (int j = 0; j < 2; j++) begin look(); tick(); end
    look();
    n_cmp++;
    if (xfers != 2 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_park: dut xfers=%0d halted=%b want 2/1", xfers, halted);
    end
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v || halted !== 1'b0 || (j == 3 && inst_pc !== 8'h10)) begin
        n_fail++; $display("FAIL halt_restart cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_redirect_halt();
    redirect = 1'b1; redirect_pc = 8'h30; halt_req = 1'b1;
    look(); tick();
    redirect = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v || (j == 3 && inst_pc !== 8'h30) || (j == 5 && halted !== 1'b1)) begin
        n_fail++; $display("FAIL redirect_halt cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      tick();
    end
`ifdef FETCH_PERF_EN
    n_cmp++;
    if (perf_redirects !== 16'(m_redirects) || perf_fetched !== 16'(m_fetched)) begin
      n_fail++; $display("FAIL perf: dut=%0d/%0d want=%0d/%0d", perf_redirects, perf_fetched,
                         m_redirects, m_fetched);
    end
`endif
    halt_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 8'h80;
    look(); tick();
    redirect = 1'b0;
    for (int j = 0; j < 4; j++) begin look(); tick(); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (act_v !== 34'h0) begin
      n_fail++; $display("FAIL reset_mid: dut=%h want=%h", act_v, 34'h0);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int j = 0; j < 5; j++) begin
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL reset_restart cyc %0d: dut=%h want=%h", j, act_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ready       = ($urandom % 10) < 7;
      redirect    = ($urandom % 20) == 0;
      redirect_pc = 8'($urandom);
      if (($urandom % 25) == 0) halt_req = ~halt_req;
      look();
      n_cmp++;
      if (act_v !== exp_v) begin
        n_fail++; $display("FAIL random cyc %0d: dut=%h want=%h", i, act_v, exp_v);
      end
      tick();
    end
    redirect = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
